mult_div_unit: RTL and testbench

//  Multicycle signed multiply/divide unit serving the MULT and DIV states of the control unit.
//  The control unit pulses a start request; this block iterates and signals done or div_zero.
//  It then holds hi/lo stable so the control unit can load them via HiWrite/LoWrite.
//  div_zero drives the control unit's Div0 exception path.

---
 rtl/mult_div_unit_pkg.sv | 15 +
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state encoding and the iteration count.
// The control unit and the bench import this package.
package mult_div_unit_pkg;

   localparam int MDU_ITER = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MULT = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One adder/subtractor is shared between the two algorithms; hi/lo hold until the next result.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MDU_ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   // {guard+upper W, multiplier W, Booth extra bit}; the guard keeps -2^(W-1) multiplicands exact
   logic [2*WIDTH+1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_bmag;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic               r_sa;
   logic               r_sb;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_dz;

   logic [WIDTH:0]     w_opx;
   logic [WIDTH:0]     w_opy;
   logic               w_sub;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_upper;
   logic [2*WIDTH+1:0] w_acc_nxt;
   logic [WIDTH-1:0]   w_rem_sh;
   logic [WIDTH-1:0]   w_quo_sh;

   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   always_comb begin
      w_rem_sh = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
      w_quo_sh = {r_quo[WIDTH-2:0], 1'b0};
      if (r_state == ST_DIV) begin
         w_opx = {1'b0, w_rem_sh};
         w_opy = {1'b0, r_bmag};
         w_sub = 1'b1;
      end else begin
         w_opx = r_acc[2*WIDTH+1:WIDTH+1];
         w_opy = {r_mcand[WIDTH-1], r_mcand};
         w_sub = (r_acc[1:0] == 2'b10);
      end
      w_sum = w_sub ? (w_opx - w_opy) : (w_opx + w_opy);
      // Booth pairs 01/10 update the upper half; 00/11 only shift
      w_upper   = (r_acc[1] ^ r_acc[0]) ? w_sum : r_acc[2*WIDTH+1:WIDTH+1];
      w_acc_nxt = {w_upper[WIDTH], w_upper, r_acc[WIDTH:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_bmag  <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_mult) begin
                  r_mcand <= b;
                  r_acc   <= {{(WIDTH+1){1'b0}}, a, 1'b0};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_MULT;
               end else if (start_div) begin
                  r_busy <= 1'b1;
                  if (b == '0) begin
                     r_done  <= 1'b1;
                     r_dz    <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_sa    <= a[WIDTH-1];
                     r_sb    <= b[WIDTH-1];
                     r_bmag  <= f_mag(b);
                     r_quo   <= f_mag(a);
                     r_rem   <= '0;
                     r_cnt   <= '0;
                     r_state <= ST_DIV;
                  end
               end
            end
            ST_MULT: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  r_hi    <= w_acc_nxt[2*WIDTH:WIDTH+1];
                  r_lo    <= w_acc_nxt[WIDTH:1];
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DIV: begin
               // a non-negative trial difference (sum MSB clear) sets the quotient bit
               if (!w_sum[WIDTH]) begin
                  r_rem <= w_sum[WIDTH-1:0];
                  r_quo <= w_quo_sh | WIDTH'(1);
               end else begin
                  r_rem <= w_rem_sh;
                  r_quo <= w_quo_sh;
               end
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_lo    <= (r_sa ^ r_sb) ? -r_quo : r_quo;
               r_hi    <= r_sa ? -r_rem : r_rem;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected hi/lo/div_zero queued at issue, checked on done.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W = MDU_ITER;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_mult = 1'b0;
   logic         start_div = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div_zero;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   typedef struct {
      string        tag;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         e_mon;
   int           n_cmp = 0;
   int           n_err = 0;
   int           edges = 0;
   int           dones = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: 64-bit signed arithmetic, truncating division, remainder follows dividend
   task automatic push_exp(input string tag, input logic is_mult, input logic [W-1:0] av,
                           input logic [W-1:0] bv);
      logic signed [63:0] sa, sbv, p, q, r;
      exp_t e;
      sa  = 64'(signed'(av));
      sbv = 64'(signed'(bv));
      e.tag = tag;
      e.dz  = 1'b0;
      if (is_mult) begin
         p    = sa * sbv;
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (bv == '0) begin
         e.dz = 1'b1;
      end else begin
         q    = sa / sbv;
         r    = sa % sbv;
         m_lo = q[31:0];
         m_hi = r[31:0];
      end
      e.hi = m_hi;
      e.lo = m_lo;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!reset && done) begin
         dones++;
         if (sb_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
         end else begin
            e_mon = sb_q.pop_front();
            chk({e_mon.tag, "_hi"}, hi, e_mon.hi);
            chk({e_mon.tag, "_lo"}, lo, e_mon.lo);
            chk({e_mon.tag, "_div_zero"}, div_zero, e_mon.dz);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      edges++;
      @(negedge clk);
   endtask

   // Drive at a negedge, let the next posedge sample, release at the following negedge
   task automatic start_op(input logic m, input logic d, input logic [W-1:0] av,
                           input logic [W-1:0] bv);
      start_mult = m;
      start_div  = d;
      a          = av;
      b          = bv;
      @(posedge clk);
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = 1'b0;
      edges      = 0;
   endtask

   task automatic wait_done(input string tag, input int lat);
      int k = 0;
      while (!done && k < 80) begin
         tick();
         k++;
      end
      chk({tag, "_latency"}, edges, lat);
      chk({tag, "_busy_in_done"}, busy, 1'b1);
      tick();
      chk({tag, "_busy_after"}, busy, 1'b0);
   endtask

   task automatic run(input string tag, input logic m, input logic [W-1:0] av,
                      input logic [W-1:0] bv);
      int lat;
      push_exp(tag, m, av, bv);
      lat = m ? 32 : ((bv == '0) ? 0 : 33);
      start_op(m, !m, av, bv);
      wait_done(tag, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_hi", hi, '0);
      chk("reset_lo", lo, '0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_div_zero", div_zero, 1'b0);

      run("mult_7_m3",     1'b1, 32'd7,         32'hFFFF_FFFD);
      run("mult_min_min",  1'b1, 32'h8000_0000, 32'h8000_0000);
      run("mult_m1_m1",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("div_m7_2",      1'b0, 32'hFFFF_FFF9, 32'd2);
      run("div_100_7",     1'b0, 32'd100,       32'd7);
      run("div_5_0",       1'b0, 32'd5,         32'd0);
      run("div_min_m1",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run("div_7_m2",      1'b0, 32'd7,         32'hFFFF_FFFE);
      run("div_big_min",   1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
      for (int i = 0; i < 3; i++) begin
         run("mult_rand", 1'b1, $urandom, $urandom);
         run("div_rand",  1'b0, $urandom, $urandom_range(1, 32'hFFFF));
      end

      // start_div while a mult is running is dropped; operands are not re-sampled
      push_exp("mult_busy_div", 1'b1, 32'd12345, 32'hFFFF_F000);
      start_op(1'b1, 1'b0, 32'd12345, 32'hFFFF_F000);
      repeat (4) tick();
      start_div = 1'b1;
      a         = 32'd99;
      b         = 32'd3;
      tick();
      start_div = 1'b0;
      wait_done("mult_busy_div", 32);

      push_exp("both_starts", 1'b1, 32'hFFFF_FF00, 32'd300);
      start_op(1'b1, 1'b1, 32'hFFFF_FF00, 32'd300);
      wait_done("both_starts", 32);

      // reset part-way through a mult aborts it without a done pulse
      start_op(1'b1, 1'b0, 32'd55, 32'd66);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_hi", hi, '0);
      chk("abort_lo", lo, '0);
      chk("abort_done", done, 1'b0);
      d0 = dones;
      repeat (40) tick();
      chk("abort_no_done", dones, d0);

      run("after_abort", 1'b1, 32'hFFFF_FFF6, 32'd10);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
